// File: rtl/goal_beat_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : goal_beat_seq_if
//  Description : Control/status bundle for the goal jingle beat sequencer.
//                The master raises trigger/stop; the slave (sequencer)
//                returns the beat index, busy and done.
//  Revision    : 1.0 - initial release
// ============================================================================
interface goal_beat_seq_if;
    logic       trigger;
    logic       stop;
    logic [7:0] beatnum;
    logic       busy;
    logic       done;

    modport master (
        output trigger,
        output stop,
        input  beatnum,
        input  busy,
        input  done
    );

    modport slave (
        input  trigger,
        input  stop,
        output beatnum,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/goal_beat_seq.sv
`default_nettype none
// ============================================================================
//  Module      : goal_beat_seq
//  Description : Plays a short goal jingle by stepping a beat index at a
//                fixed tempo. A trigger rising edge starts (or restarts)
//                playback, stop aborts it, done pulses at the natural end.
//  Revision    : 1.0 - initial release
// ============================================================================
module goal_beat_seq #(
    parameter int         CLK_HZ    = 100000000,
    parameter int         BEAT_HZ   = 8,
    parameter int         NUM_BEATS = 2,
    parameter logic [7:0] IDLE_BEAT = 8'd255
) (
    input  wire                  clk,
    input  wire                  rst_n,
    goal_beat_seq_if.slave       bus
);

    localparam int          c_BEAT_CYCLES = CLK_HZ / BEAT_HZ;
    localparam logic [31:0] c_LAST_TICK   = 32'(c_BEAT_CYCLES - 1);
    localparam logic [7:0]  c_LAST_BEAT   = 8'(NUM_BEATS - 1);

    localparam logic [0:0]  c_ST_IDLE = 1'b0;
    localparam logic [0:0]  c_ST_PLAY = 1'b1;

    logic [0:0]  r_state;
    logic        r_trig_q;
    logic [31:0] r_tempo;
    logic [7:0]  r_beatnum;
    logic        r_busy;
    logic        r_done;

    // Rising edge of trigger; trig_q resets high so a trigger already
    // asserted when reset releases is not mistaken for a new goal.
    wire w_rise = bus.trigger & ~r_trig_q;

    // Sequencer state, tempo counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_trig_q  <= 1'b1;
            r_tempo   <= 32'd0;
            r_beatnum <= IDLE_BEAT;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_trig_q <= bus.trigger;
            r_done   <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_tempo   <= 32'd0;
                    r_beatnum <= IDLE_BEAT;
                    r_busy    <= 1'b0;
                    // stop has priority: a rise seen together with stop is dropped
                    if (w_rise && !bus.stop) begin
                        r_state   <= c_ST_PLAY;
                        r_beatnum <= 8'd0;
                        r_busy    <= 1'b1;
                    end
                end
                c_ST_PLAY: begin
                    if (bus.stop) begin
                        r_state   <= c_ST_IDLE;
                        r_tempo   <= 32'd0;
                        r_beatnum <= IDLE_BEAT;
                        r_busy    <= 1'b0;
                    end else if (w_rise) begin
                        // retrigger wins even over the final beat advance
                        r_tempo   <= 32'd0;
                        r_beatnum <= 8'd0;
                    end else if (r_tempo == c_LAST_TICK) begin
                        r_tempo <= 32'd0;
                        if (r_beatnum == c_LAST_BEAT) begin
                            r_state   <= c_ST_IDLE;
                            r_beatnum <= IDLE_BEAT;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_beatnum <= r_beatnum + 8'd1;
                        end
                    end else begin
                        r_tempo <= r_tempo + 32'd1;
                    end
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_tempo   <= 32'd0;
                    r_beatnum <= IDLE_BEAT;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.beatnum = r_beatnum;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule
`default_nettype wire
